reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_arb_pkg.sv | 13 +
 rtl/rr_picker.sv | 29 ++
 rtl/reg_write_arbiter.sv | 95 +++++++++
 tb/tb_reg_write_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the round-robin shared-register write arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    localparam int N_REQ_DEF = 4;
    localparam int DW_DEF    = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, wrapping.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             valid,
    output logic [PW-1:0]    w
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        valid = 1'b0;
        w     = '0;
        idx   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) begin
                valid = 1'b1;
                w     = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates N_REQ writers onto one shared register: IDLE -> GRANT -> ACK, round-robin.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] din,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       q,
    output logic                busy
);

    localparam int PW = $clog2(N_REQ);

    arb_state_t       state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [PW-1:0]    w_lat, w_lat_n;
    logic [N_REQ-1:0] gnt_n, ack_n;
    logic [DW-1:0]    q_n;
    logic             busy_n;
    logic             pick_valid;
    logic [PW-1:0]    pick_w;

    rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_picker (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .w     (pick_w)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        w_lat_n = w_lat;
        gnt_n   = '0;
        ack_n   = '0;
        q_n     = q;
        busy_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n       = GRANT;
                    w_lat_n       = pick_w;
                    gnt_n[pick_w] = 1'b1;
                    busy_n        = 1'b1;
                end
            end
            GRANT: begin
                // Only the latched winner's request matters; dropping it aborts the write.
                if (req[w_lat]) begin
                    state_n      = ACK;
                    q_n          = din[int'(w_lat)*DW +: DW];
                    ack_n[w_lat] = 1'b1;
                    busy_n       = 1'b1;
                    ptr_n        = (w_lat == PW'(N_REQ - 1)) ? '0 : w_lat + 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            w_lat <= '0;
            gnt   <= '0;
            ack   <= '0;
            q     <= '0;
            busy  <= 1'b0;
        end else begin
            ptr   <= ptr_n;
            w_lat <= w_lat_n;
            gnt   <= gnt_n;
            ack   <= ack_n;
            q     <= q_n;
            busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed-vector bench for reg_write_arbiter with hand-computed expectations.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        busy;

    int vecs = 0;
    int errs = 0;

    reg_write_arbiter #(.N_REQ(4), .DW(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .din  (din),
        .gnt  (gnt),
        .ack  (ack),
        .q    (q),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'($urandom);
        din = $urandom;
        step();
        req = 4'($urandom);
        din = $urandom;
        step();
        vecs++; if (gnt !== 4'b0000) begin errs++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        vecs++; if (ack !== 4'b0000) begin errs++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vecs++; if (q !== 8'h00) begin errs++; $display("FAIL reset_q got=%h exp=00", q); end
        req = 4'b0000;
        rst = 1'b0;
        step();
        vecs++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errs++; $display("FAIL idle_no_req gnt=%b busy=%b exp 0000/0", gnt, busy); end
    endtask

    task automatic test_single();
        din = 32'h0000_00A5;
        req = 4'b0001;
        step();
        vecs++; if (gnt !== 4'b0001) begin errs++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy_g got=%b exp=1", busy); end
        vecs++; if (q !== 8'h00) begin errs++; $display("FAIL single_q_early got=%h exp=00", q); end
        step();
        vecs++; if (ack !== 4'b0001) begin errs++; $display("FAIL single_ack got=%b exp=0001", ack); end
        vecs++; if (q !== 8'hA5) begin errs++; $display("FAIL single_q got=%h exp=a5", q); end
        vecs++; if (gnt !== 4'b0000) begin errs++; $display("FAIL single_gnt_clr got=%b exp=0000", gnt); end
        req = 4'b0000;
        step();
        vecs++; if (busy !== 1'b0 || ack !== 4'b0000) begin errs++; $display("FAIL single_done busy=%b ack=%b exp 0/0000", busy, ack); end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1;
        step();
        rst = 1'b0;
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            vecs++; if (gnt !== 4'(1 << i)) begin errs++; $display("FAIL fair_gnt%0d got=%b exp=%b", i, gnt, 4'(1 << i)); end
            step();
            vecs++; if (ack !== 4'(1 << i)) begin errs++; $display("FAIL fair_ack%0d got=%b exp=%b", i, ack, 4'(1 << i)); end
            vecs++; if (q !== exp_q[i]) begin errs++; $display("FAIL fair_q%0d got=%h exp=%h", i, q, exp_q[i]); end
            req[i] = 1'b0;
            step();
            vecs++; if (busy !== 1'b0 || gnt !== 4'b0000 || ack !== 4'b0000) begin
                errs++; $display("FAIL fair_idle%0d busy=%b gnt=%b ack=%b exp 0/0000/0000", i, busy, gnt, ack);
            end
        end
    endtask

    task automatic test_wrap();
        req = 4'b1001;
        step();
        vecs++; if (gnt !== 4'b0001) begin errs++; $display("FAIL wrap_gnt0 got=%b exp=0001", gnt); end
        step();
        vecs++; if (ack !== 4'b0001 || q !== 8'h11) begin errs++; $display("FAIL wrap_ack0 ack=%b q=%h exp 0001/11", ack, q); end
        req = 4'b1000;
        step();
        step();
        vecs++; if (gnt !== 4'b1000) begin errs++; $display("FAIL wrap_gnt3 got=%b exp=1000", gnt); end
        step();
        vecs++; if (ack !== 4'b1000 || q !== 8'h44) begin errs++; $display("FAIL wrap_ack3 ack=%b q=%h exp 1000/44", ack, q); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_abort();
        req = 4'b0010;
        step();
        vecs++; if (gnt !== 4'b0010 || busy !== 1'b1) begin errs++; $display("FAIL abort_gnt gnt=%b busy=%b exp 0010/1", gnt, busy); end
        req = 4'b0000;
        step();
        vecs++; if (gnt !== 4'b0000 || busy !== 1'b0 || ack !== 4'b0000) begin
            errs++; $display("FAIL abort_idle gnt=%b busy=%b ack=%b exp 0000/0/0000", gnt, busy, ack);
        end
        vecs++; if (q !== 8'h44) begin errs++; $display("FAIL abort_q got=%h exp=44", q); end
        step();
        vecs++; if (ack !== 4'b0000) begin errs++; $display("FAIL abort_no_ack got=%b exp=0000", ack); end
        req = 4'b0011;
        step();
        vecs++; if (gnt !== 4'b0001) begin errs++; $display("FAIL abort_ptr got=%b exp=0001", gnt); end
        step();
        vecs++; if (ack !== 4'b0001 || q !== 8'h11) begin errs++; $display("FAIL abort_after ack=%b q=%h exp 0001/11", ack, q); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid();
        din = {8'h44, 8'h33, 8'h5A, 8'h11};
        req = 4'b0010;
        step();
        step();
        vecs++; if (q !== 8'h5A || ack !== 4'b0010) begin errs++; $display("FAIL mid_setup q=%h ack=%b exp 5a/0010", q, ack); end
        req = 4'b0100;
        step();
        step();
        vecs++; if (gnt !== 4'b0100) begin errs++; $display("FAIL mid_gnt got=%b exp=0100", gnt); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vecs++; if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
            errs++; $display("FAIL mid_rst gnt=%b ack=%b busy=%b exp 0000/0000/0", gnt, ack, busy);
        end
        vecs++; if (q !== 8'h00) begin errs++; $display("FAIL mid_rst_q got=%h exp=00", q); end
        req = 4'b1010;
        step();
        vecs++; if (gnt !== 4'b0010 || ack !== 4'b0000) begin errs++; $display("FAIL mid_ptr0 gnt=%b ack=%b exp 0010/0000", gnt, ack); end
        step();
        vecs++; if (ack !== 4'b0010 || q !== 8'h5A) begin errs++; $display("FAIL mid_write ack=%b q=%h exp 0010/5a", ack, q); end
        req = 4'b0000;
        step();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        din = '0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
